// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified memory-port arbiter.
//   state_t      : arbiter FSM states (IDLE, ISSUE, RESP)
//   OWN_I/OWN_D  : owner encoding of the transaction in flight (fetch / data)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel: winner selection between fetch and data requesters.
// Data wins by default. With MEM_ARB_STARVE_GUARD_EN defined, a saturating
// counter of data grants made while fetch waits forces a fetch grant once it
// reaches STARVE_LIMIT.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (counter only)
//   i_req      : fetch request
//   d_req      : data request
//   decide     : an IDLE grant decision is being made this cycle
//   owner      : selected requester (OWN_I / OWN_D), combinational
module mem_arb_sel
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic decide,
    output logic owner
);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == LIMIT) && i_req && d_req;

    always_comb begin
        owner = d_req ? OWN_D : OWN_I;
        if (starved) begin
            owner = OWN_I;
        end
    end

    // Counts data grants while fetch is waiting; any fetch grant or a
    // decision without a pending fetch means fetch is not starving.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (decide) begin
            if (owner == OWN_I || !i_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end
`else
    localparam int unused_limit = STARVE_LIMIT;
    logic unused_sel;

    assign owner      = d_req ? OWN_D : OWN_I;
    assign unused_sel = ^{clk, reset, i_req, decide};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between the instruction-fetch
// path and the data load/store path through a registered IDLE/ISSUE/RESP FSM.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (fetch starvation guard).
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   i_req, i_addr                   : fetch request (level) and address
//   i_ack, i_rdata                  : fetch completion pulse and fetched word
//   d_req, d_we, d_addr, d_wdata,
//   d_wstrb                         : data request (level) and its fields
//   d_ack, d_rdata                  : data completion pulse and load data
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wstrb            : latched request towards memory
//   mem_ack, mem_rdata              : memory completion and read data
//   busy                            : FSM is not in IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    state_t state;
    logic   owner_q;
    logic   sel_owner;
    logic   decide;

    assign decide = (state == IDLE) && (i_req || d_req);
    assign busy   = (state != IDLE);

    mem_arb_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_sel (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .d_req  (d_req),
        .decide (decide),
        .owner  (sel_owner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner_q   <= OWN_I;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (decide) begin
                        owner_q <= sel_owner;
                        mem_req <= 1'b1;
                        state   <= ISSUE;
                        if (sel_owner == OWN_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            // Loads must not present byte enables.
                            mem_wstrb <= d_we ? d_wstrb : '0;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        // The ack is raised here so it is visible for
                        // exactly the one RESP cycle.
                        if (owner_q == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A wait-state memory
// model and an ack monitor pop expected transactions from scoreboard queues
// filled by the stimulus. Build with MEM_ARB_STARVE_GUARD_EN to exercise the
// starvation guard expectations.
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        bit          exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    txn_t        mem_q[$];
    txn_t        ack_q[$];
    txn_t        mt;
    txn_t        at;
    int          checks = 0;
    int          errors = 0;
    int          mem_waits = 0;
    int          wcnt = 0;
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;
    vec_t        vecs[6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h2008_0045;
    endfunction

    function automatic vec_t mk(input bit is_d, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int waits, input bit ewe, input logic [3:0] ews,
                                input logic [31:0] erd);
        vec_t v;
        v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.waits = waits; v.exp_we = ewe; v.exp_wstrb = ews; v.exp_rdata = erd;
        return v;
    endfunction

    function automatic txn_t to_txn(input vec_t v);
        txn_t t;
        t.is_d = v.is_d; t.we = v.exp_we; t.addr = v.addr; t.wdata = v.wdata;
        t.wstrb = v.exp_wstrb; t.rdata = v.exp_rdata;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen where none was allowed", name);
    endtask

    // Memory model: acknowledges after mem_waits wait cycles and checks the
    // request fields on every cycle mem_req is high.
    always @(negedge clk) begin
        if (reset) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (mem_req) begin
            if (mem_q.size() == 0) begin
                fail("mem_unexpected_req");
            end else begin
                mt = mem_q[0];
                check("mem_addr", mem_addr, mt.addr);
                check("mem_we", mem_we, mt.we);
                check("mem_wstrb", mem_wstrb, mt.wstrb);
                if (mt.we) check("mem_wdata", mem_wdata, mt.wdata);
            end
            if (wcnt == mem_waits) begin
                mem_ack = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wcnt = 0;
                if (mem_q.size() > 0) mem_q.delete(0);
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Ack monitor: order, data and non-owner hold behaviour.
    always @(negedge clk) begin
        if (!reset) begin
            if (i_ack && d_ack) fail("both_acks");
            if (i_ack || d_ack) begin
                if (ack_q.size() == 0) begin
                    fail("unexpected_ack");
                end else begin
                    at = ack_q.pop_front();
                    check("ack_port", d_ack, at.is_d);
                    if (at.is_d) begin
                        check("d_rdata", d_rdata, at.rdata);
                        check("i_rdata_hold", i_rdata, last_i);
                        last_d = at.rdata;
                    end else begin
                        check("i_rdata", i_rdata, at.rdata);
                        check("d_rdata_hold", d_rdata, last_d);
                        last_i = at.rdata;
                    end
                end
            end
        end
    end

    task automatic run_txn(input vec_t v, input string name);
        int k;
        bit got;
        @(posedge clk); #1;
        mem_waits = v.waits;
        mem_q.push_back(to_txn(v));
        ack_q.push_back(to_txn(v));
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        k = 0;
        got = 1'b0;
        while (!got && k < 64) begin
            @(negedge clk);
            k++;
            if (k == 1) check({name, "_mem_req_early"}, mem_req, 0);
            if (k >= 2 && k <= v.waits + 2) check({name, "_mem_req"}, mem_req, 1);
            if (k == 2) check({name, "_busy"}, busy, 1);
            if (v.is_d ? d_ack : i_ack) got = 1'b1;
        end
        if (!got) fail({name, "_timeout"});
        else check({name, "_latency"}, k, v.waits + 3);
        check({name, "_mem_req_drop"}, mem_req, 0);
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_acks"}, {i_ack, d_ack}, 0);
    endtask

    initial begin
        int   k;
        int   dk;
        int   ik;
        int   dcnt;
        int   nd;
        bit   done;
        vec_t v;

        vecs[0] = mk(0, 0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 4'h0, 32'h2008_0005);
        vecs[1] = mk(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3, 1, 4'hF, 32'h2008_0145);
        vecs[2] = mk(1, 0, 32'h0000_0204, 32'h1111_1111, 4'h3, 1, 0, 4'h0, 32'h2008_0241);
        vecs[3] = mk(1, 1, 32'h0000_0308, 32'h1234_5678, 4'h5, 0, 1, 4'h5, 32'h2008_034D);
        vecs[4] = mk(0, 0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2, 0, 4'h0, 32'hDFF7_FFB9);
        vecs[5] = mk(1, 0, 32'h0000_0003, 32'h0,         4'hF, 0, 0, 4'h0, 32'h2008_0046);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_fields", {mem_we, mem_addr, mem_wdata, mem_wstrb}, 0);
        check("rst_acks", {i_ack, d_ack}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Simultaneous requests: data first, fetch in the following IDLE
        @(posedge clk); #1;
        mem_waits = 0;
        v = mk(1, 0, 32'h200, 32'h55, 4'hF, 0, 0, 4'h0, 32'h2008_0245);
        mem_q.push_back(to_txn(v)); ack_q.push_back(to_txn(v));
        v = mk(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 4'h0, 32'h2008_0045);
        mem_q.push_back(to_txn(v)); ack_q.push_back(to_txn(v));
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h55; d_wstrb = 4'hF;
        k = 0; dk = 0; ik = 0; done = 1'b0;
        while (!done && k < 64) begin
            @(negedge clk);
            k++;
            if (i_ack) begin
                ik = k;
                done = 1'b1;
            end
            if (d_ack) begin
                dk = k;
                @(posedge clk); #1;
                d_req = 1'b0;
            end
        end
        if (!done) fail("collide_timeout");
        check("collide_d_first", dk, 3);
        check("collide_i_after", ik, 6);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        check("collide_idle", busy, 0);

        // Continuous data traffic with fetch held
        nd = GUARD ? 4 : 6;
        @(posedge clk); #1;
        mem_waits = 0;
        v = mk(1, 1, 32'h300, 32'hCAFE_F00D, 4'h3, 0, 1, 4'h3, 32'h2008_0345);
        for (int i = 0; i < nd; i++) begin
            mem_q.push_back(to_txn(v)); ack_q.push_back(to_txn(v));
        end
        v = mk(0, 0, 32'h44, 32'h0, 4'h0, 0, 0, 4'h0, 32'h2008_0001);
        mem_q.push_back(to_txn(v)); ack_q.push_back(to_txn(v));
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'h3;
        k = 0; dcnt = 0; done = 1'b0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            if (i_ack) done = 1'b1;
            if (d_ack) begin
                dcnt++;
                if (!GUARD && dcnt == nd) begin
                    @(posedge clk); #1;
                    d_req = 1'b0;
                end
            end
        end
        if (!done) fail("starve_timeout");
        check("starve_data_grants", dcnt, nd);
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        check("starve_idle", busy, 0);
        check("starve_q_empty", ack_q.size(), 0);

        // Reset during ISSUE with a slow memory
        @(posedge clk); #1;
        mem_waits = 5;
        v = mk(0, 0, 32'h80, 32'h0, 4'h0, 5, 0, 4'h0, 32'h2008_00C5);
        mem_q.push_back(to_txn(v)); ack_q.push_back(to_txn(v));
        i_req = 1'b1; i_addr = 32'h80;
        repeat (3) @(negedge clk);
        check("abort_pre_mem_req", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_busy", busy, 0);
        check("abort_acks", {i_ack, d_ack}, 0);
        check("abort_rdata", {i_rdata, d_rdata}, 0);
        i_req = 1'b0;
        mem_q.delete();
        ack_q.delete();
        last_i = '0;
        last_d = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 0);
        run_txn(mk(0, 0, 32'hC0, 32'h0, 4'h0, 1, 0, 4'h0, 32'h2008_0085), "post_abort");

        repeat (3) @(negedge clk);
        check("end_mem_q_empty", mem_q.size(), 0);
        check("end_ack_q_empty", ack_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the CPU's single unified memory port between the instruction-fetch path and the data load/store path. It sits between the CPU core and the memory model. It serialises accesses through a registered request/acknowledge FSM. Data accesses win by default; an optional starvation guard bounds how long fetch can wait.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (guard only)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DATA_W  fetched word
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  byte enables for store
- d_ack  out  1  one-cycle pulse, d_rdata valid on loads
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request, level until mem_ack
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  DATA_W  valid with mem_ack
- busy  out  1  high in any state but IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req, select winner, latch its fields into mem_* registers, record owner, go ISSUE. Else stay.
- Selection: d_req wins over i_req. The starvation guard below is the only exception.
- Fetch grants drive mem_we=0 and mem_wstrb=0. Store grants pass d_wstrb unchanged. Loads drive mem_wstrb=0.
- ISSUE: mem_req=1 and fields stable. On mem_ack, latch mem_rdata into the owner's rdata register and go RESP.
- RESP: pulse the owner's ack for exactly one cycle, then go IDLE.
- Non-owner rdata registers hold their previous value.
- Addresses pass through unmodified. No alignment checks.
- Requester contract: drop req on the edge after ack. A req still high in IDLE is a new request.
- Dropping req before ack is a protocol violation. The latched transaction still completes.

## Timing
- Reset (async): state IDLE, all outputs 0, rdata registers 0, starvation counter 0.
- Reset mid-transaction aborts it. mem_req falls asynchronously and no ack is issued.
- Latency: req sampled high in IDLE at edge N. mem_req is high in cycle N+1.
- With mem_ack in cycle N+1 (zero-wait memory), ack is high in cycle N+2 and IDLE is reached at N+3.
- Minimum 3 cycles per transaction. Memory wait states add 1 cycle each.
- Simultaneous i_req and d_req in IDLE: data granted, fetch waits. Fetch is granted in the IDLE after data's RESP if i_req is still high.
- mem_ack outside ISSUE is ignored.
- i_ack and d_ack are never high in the same cycle.

## Configuration
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments on each data grant made while i_req is high.
  - The counter clears on any fetch grant, or on an IDLE decision with i_req low.
  - When the counter equals STARVE_LIMIT and both requests are high, fetch is granted.
  - The counter saturates at STARVE_LIMIT.
- Undefined: strict data priority. Counter logic is absent and STARVE_LIMIT is unused.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESP}
  - owner constants OWN_I=0, OWN_D=1
- Sub-module mem_arb_sel: combinational winner selection plus the guarded starvation counter.
- Top level holds the FSM, the request latches and the rdata registers.

## Test plan
- Reset release, then i_req with i_addr=0x00000040 against zero-wait memory.
  - Required: mem_req in cycle 1 with mem_addr=0x40 and mem_we=0.
  - Required: i_ack in cycle 2 with i_rdata=mem_rdata=0x20080005.
- d_req store: d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF, memory with 3 wait states.
  - Required: mem_req held for 4 cycles with fields stable.
  - Required: d_ack exactly one cycle after mem_ack.
- i_req and d_req raised together at 0x0 and 0x200.
  - Required: the data transaction completes first, then the fetch.
  - Required: no cycle where both acks are high.
- Guard defined, STARVE_LIMIT=4, d_req re-raised continuously with i_req held.
  - Required: the fifth grant goes to fetch.
  - Undefined macro: fetch is never granted while d_req stays high.
- Assert reset during ISSUE with a 5-wait-state memory.
  - Required: mem_req=0 immediately, no ack, state IDLE.
  - Required: a new i_req after release completes normally.
